// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream packet generator emitting incrementing-pattern packets per command
module axis_pkt_gen #(
  parameter int AXIS_TDATA_WIDTH = 8,
  parameter int LEN_WIDTH        = 16,
  parameter int PKT_COUNT_WIDTH  = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic [LEN_WIDTH-1:0]        i_cmd_len,
  input  logic [AXIS_TDATA_WIDTH-1:0] i_cmd_seed,
  input  logic                        i_cmd_tid,
  input  logic                        i_cmd_tdest,
  input  logic                        i_cmd_sof,
  output logic                        o_m_axis_tvalid,
  input  logic                        i_m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] o_m_axis_tdata,
  output logic                        o_m_axis_tlast,
  output logic                        o_m_axis_tstrb,
  output logic                        o_m_axis_tkeep,
  output logic                        o_m_axis_tid,
  output logic                        o_m_axis_tdest,
  output logic                        o_m_axis_tuser,
  output logic                        o_busy,
  output logic                        o_zero_len,
  output logic [PKT_COUNT_WIDTH-1:0]  o_pkt_count
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t                      state_q, state_d;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic [PKT_COUNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
  logic                        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                        tid_q, tid_d, tdest_q, tdest_d, zero_len_q, zero_len_d;
  // next state: load a packet from an accepted command, then step one beat per handshake
  always_comb begin
    state_d     = state_q;
    tdata_d     = tdata_q;
    cnt_d       = cnt_q;
    pkt_count_d = pkt_count_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    tid_d       = tid_q;
    tdest_d     = tdest_q;
    zero_len_d  = 1'b0;
    if (state_q == IDLE) begin
      if (i_cmd_valid && i_cmd_len == '0) begin
        zero_len_d = 1'b1;
      end else if (i_cmd_valid) begin
        state_d  = SEND;
        tdata_d  = i_cmd_seed;
        cnt_d    = i_cmd_len - LEN_WIDTH'(1);
        tvalid_d = 1'b1;
        tlast_d  = i_cmd_len == LEN_WIDTH'(1);
        tuser_d  = i_cmd_sof;
        tid_d    = i_cmd_tid;
        tdest_d  = i_cmd_tdest;
      end
    end else if (i_m_axis_tready) begin
      if (tlast_q) begin
        state_d     = IDLE;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        tuser_d     = 1'b0;
        pkt_count_d = pkt_count_q + PKT_COUNT_WIDTH'(1);
      end else begin
        tdata_d = tdata_q + AXIS_TDATA_WIDTH'(1);
        cnt_d   = cnt_q - LEN_WIDTH'(1);
        tuser_d = 1'b0;
        tlast_d = cnt_q == LEN_WIDTH'(1);
      end
    end
  end
  // state registers; reset discards any packet in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      tdata_q     <= '0;
      cnt_q       <= '0;
      pkt_count_q <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      tid_q       <= 1'b0;
      tdest_q     <= 1'b0;
      zero_len_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tdata_q     <= tdata_d;
      cnt_q       <= cnt_d;
      pkt_count_q <= pkt_count_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      tid_q       <= tid_d;
      tdest_q     <= tdest_d;
      zero_len_q  <= zero_len_d;
    end
  end
  assign o_cmd_ready     = state_q == IDLE && !i_rst;
  assign o_m_axis_tvalid = tvalid_q;
  assign o_m_axis_tdata  = tdata_q;
  assign o_m_axis_tlast  = tlast_q;
  assign o_m_axis_tstrb  = tvalid_q;
  assign o_m_axis_tkeep  = tvalid_q;
  assign o_m_axis_tid    = tid_q;
  assign o_m_axis_tdest  = tdest_q;
  assign o_m_axis_tuser  = tuser_q;
  assign o_busy          = state_q == SEND;
  assign o_zero_len      = zero_len_q;
  assign o_pkt_count     = pkt_count_q;
endmodule
